firebird7_in_gate1_tessent_tdr_dmux_ctrl: RTL and testbench
===========================================================

# firebird7_in_gate1_tessent_tdr_dmux_ctrl

IJTAG test data register (TDR) that drives the select and test-data inputs of the gate1 3-bit data mux (`firebird7_in_gate1_tessent_data_mux_w3_*`). It sits directly upstream of that mux on the IJTAG network. It implements capture, shift and update stages. Its update-stage outputs switch the mux between functional data and scan-loaded data. Capture observes the mux output so the host can read back what is being driven.

## Interface
Parameters:
- `WIDTH`, 3: data bits driven to the mux. The shift path length is `WIDTH+1`.

Ports:
- `ijtag_tck` input 1: the only clock. All state changes on the rising edge.
- `ijtag_reset` input 1: reset, **synchronous, active-high**.
- `ijtag_sel` input 1: this TDR is selected on the scan path.
- `ijtag_ce` input 1: capture enable.
- `ijtag_se` input 1: shift enable.
- `ijtag_ue` input 1: update enable.
- `ijtag_si` input 1: scan in.
- `ijtag_so` output 1: scan out.
- `capture_data_in` input WIDTH: mux `data_out`, observed on capture.
- `ijtag_select` output 1: update-stage select bit, goes to mux `ijtag_select`.
- `ijtag_data_out` output WIDTH: update-stage data, goes to mux `ijtag_data_in`.

## Operation
- Shift register `sr[WIDTH:0]`:
  - `sr[WIDTH]` is the select bit.
  - `sr[WIDTH-1:0]` is the data.
- Update register `ur[WIDTH:0]`:
  - `ijtag_select = ur[WIDTH]`.
  - `ijtag_data_out = ur[WIDTH-1:0]`.
- Every action below requires `ijtag_sel=1`. When `ijtag_sel=0`, `sr` and `ur` hold.
- Capture (`ce=1`): `sr <= {ur[WIDTH], capture_data_in}`.
- Shift (`se=1`, `ce=0`): `sr <= {ijtag_si, sr[WIDTH:1]}`. The LSB shifts out first.
- Update (`ue=1`): `ur <= sr`, using the `sr` value before the edge.
  - Select and data update in the same edge, so the mux never sees a mixed state.
- Priority: capture over shift.
- Update is independent of capture and shift.
  - If `ue` and `se` are both asserted in one cycle, `ur` takes the pre-shift `sr` and `sr` shifts.
- `ijtag_so = sr[0]`. It is combinational from the register and is not gated by `ijtag_sel`.
- Reset (`ijtag_reset=1` at a rising edge):
  - `sr` and `ur` go to all-zero.
  - Reset overrides all enables in that cycle.
  - Reset during a shift abandons the partial load.

## Timing
- Reset values:
  - `ijtag_select=0`, so the mux passes functional data.
  - `ijtag_data_out=0`.
  - `ijtag_so=0`.
- Shift: one bit per `ijtag_tck`. `ijtag_si` appears at `ijtag_so` after `WIDTH+1` shift cycles.
- Capture: `capture_data_in` is sampled at the edge where `ce=1`. It is visible on `ijtag_so` (bit 0) immediately after that edge.
- Update: `ijtag_select` and `ijtag_data_out` change one edge after `ue=1` is sampled. The mux output changes combinationally after that.
- No wrap-around or overflow state. Continuous shifting simply streams through.

## Configuration
- Macro: `FIREBIRD7_TDR_CAPTURE_EN`.
- Defined: capture behaves as in Operation.
- Undefined:
  - `ijtag_ce` is ignored.
  - `sr` is unchanged in a cycle with `ce=1` and `se=0`.
  - `capture_data_in` is left unconnected internally.
  - `ijtag_so` reflects only shifted data.

## Structure
- Shared package `firebird7_in_gate1_tdr_pkg`:
  - `TDR_LEN = WIDTH+1` helper.
  - `SEL_BIT` index constant.
  - Reset value constant `TDR_RESET = '0`.
- No sub-module. A single flat module of about 120–150 lines.
- The bench instantiates this block together with the existing data mux, connecting `capture_data_in` to the mux `data_out`.

## Test plan
All scenarios use `WIDTH=3`.
- Reset:
  - Assert `ijtag_reset` for 1 cycle with `sel=se=ue=1`.
  - Expect `ijtag_select=0`, `ijtag_data_out=3'b000`, `ijtag_so=0`.
  - Expect mux `data_out` = functional input `3'b101`.
- Shift and update:
  - Shift in `1,0,1,1` (LSB first: `sr=4'b1101`), then pulse `ue`.
  - Expect `ijtag_select=1` and `ijtag_data_out=3'b101` one edge later.
  - Expect mux `data_out=3'b101`, independent of the functional input `3'b010`.
- Capture:
  - With `ur=4'b1110` and mux out `3'b110`, pulse `ce`, then shift 4 cycles.
  - Expect `ijtag_so` sequence `0,1,1,1`.
- Deselect:
  - With `sel=0`, toggle `se`, `ue` and `ce`.
  - Expect `sr`, `ur` and outputs unchanged.
- Simultaneous `ue` and `se`:
  - With `sr=4'b0110` and `si=1`, assert both for one cycle.
  - Expect `ur=4'b0110` and `sr=4'b1011`.
- Macro off:
  - Pulse `ce` with `sr=4'b1001`.
  - Expect `sr` still `4'b1001` and `ijtag_so=1`.

Source files
------------

// File: rtl/firebird7_in_gate1_tdr_pkg.sv
// Shared constants for the gate1 data-mux control TDR: shift-path length helper,
// select-bit index and reset value.
package firebird7_in_gate1_tdr_pkg;

  localparam int TDR_WIDTH = 3;

  function automatic int tdr_len(input int width);
    return width + 1;
  endfunction

  localparam int TDR_LEN = tdr_len(TDR_WIDTH);
  localparam int SEL_BIT = TDR_WIDTH;
  localparam logic [TDR_LEN-1:0] TDR_RESET = '0;

endpackage

// File: rtl/firebird7_in_gate1_tessent_tdr_dmux_ctrl.sv
// IJTAG TDR driving select/test-data of the gate1 3-bit data mux (capture/shift/update).
// Optional capture stage enabled by defining FIREBIRD7_TDR_CAPTURE_EN.
module firebird7_in_gate1_tessent_tdr_dmux_ctrl
  import firebird7_in_gate1_tdr_pkg::*;
#(
  parameter int WIDTH = TDR_WIDTH
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_ce,
  input  logic             ijtag_se,
  input  logic             ijtag_ue,
  input  logic             ijtag_si,
  output logic             ijtag_so,
  input  logic [WIDTH-1:0] capture_data_in,
  output logic             ijtag_select,
  output logic [WIDTH-1:0] ijtag_data_out
);

  localparam int LEN = tdr_len(WIDTH);
  localparam int SEL = SEL_BIT + (WIDTH - TDR_WIDTH);

  logic [LEN-1:0] sr;
  logic [LEN-1:0] ur;
  logic [LEN-1:0] sr_next;

`ifndef FIREBIRD7_TDR_CAPTURE_EN
  // Capture disabled: these inputs are intentionally left dangling.
  logic unused_capture;
  assign unused_capture = ijtag_ce ^ (^capture_data_in);
`endif

  always_comb begin
    sr_next = sr;
`ifdef FIREBIRD7_TDR_CAPTURE_EN
    if (ijtag_ce) begin
      sr_next = {ur[SEL], capture_data_in};
    end else if (ijtag_se) begin
      sr_next = {ijtag_si, sr[LEN-1:1]};
    end
`else
    if (ijtag_se) begin
      sr_next = {ijtag_si, sr[LEN-1:1]};
    end
`endif
  end

  // Update samples the pre-edge sr, so select and data switch together.
  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      sr <= LEN'(TDR_RESET);
      ur <= LEN'(TDR_RESET);
    end else if (ijtag_sel) begin
      sr <= sr_next;
      if (ijtag_ue) begin
        ur <= sr;
      end
    end
  end

  assign ijtag_so       = sr[0];
  assign ijtag_select   = ur[SEL];
  assign ijtag_data_out = ur[WIDTH-1:0];

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_dmux_ctrl.sv
// Directed scoreboard bench for the gate1 mux-control TDR, with a behavioural
// stand-in for the downstream 3-bit data mux.
module tb_firebird7_in_gate1_tessent_tdr_dmux_ctrl;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst, sel, ce, se, ue, si;
  logic         so, select;
  logic [W-1:0] data_out, func_data, mux_out;

  int checks = 0;
  int errors = 0;

  string       q_tag[$];
  logic [7:0]  q_exp[$];

  always #5 clk = ~clk;

  // Downstream mux: scan data when selected, functional data otherwise.
  assign mux_out = select ? data_out : func_data;

  firebird7_in_gate1_tessent_tdr_dmux_ctrl #(.WIDTH(W)) dut (
    .ijtag_tck       (clk),
    .ijtag_reset     (rst),
    .ijtag_sel       (sel),
    .ijtag_ce        (ce),
    .ijtag_se        (se),
    .ijtag_ue        (ue),
    .ijtag_si        (si),
    .ijtag_so        (so),
    .capture_data_in (mux_out),
    .ijtag_select    (select),
    .ijtag_data_out  (data_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [7:0] val);
    q_tag.push_back(tag);
    q_exp.push_back(val);
  endtask

  task automatic check(input logic [7:0] obs);
    string      tag;
    logic [7:0] exp;
    checks++;
    if (q_exp.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_underflow: observed %0h required an expectation", obs);
    end else begin
      tag = q_tag.pop_front();
      exp = q_exp.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
    end
  endtask

  task automatic shift_bit(input logic b);
    se = 1'b1;
    si = b;
    step();
    se = 1'b0;
    si = 1'b0;
  endtask

  initial begin
    rst = 1'b0; sel = 1'b0; ce = 1'b0; se = 1'b0; ue = 1'b0; si = 1'b0;
    func_data = 3'b101;
    #2;

    // Reset with enables asserted
    rst = 1'b1; sel = 1'b1; se = 1'b1; ue = 1'b1; si = 1'b1;
    expect_val("rst_select", 8'h0);
    expect_val("rst_data", 8'h0);
    expect_val("rst_so", 8'h0);
    expect_val("rst_mux", 8'h5);
    expect_val("rst_sr", 8'h0);
    step();
    check({7'd0, select});
    check({5'd0, data_out});
    check({7'd0, so});
    check({5'd0, mux_out});
    check({4'd0, dut.sr});
    rst = 1'b0; se = 1'b0; ue = 1'b0; si = 1'b0;

    // Shift 1,0,1,1 then update
    func_data = 3'b010;
    shift_bit(1'b1);
    expect_val("sh1_sr", 8'h8); check({4'd0, dut.sr});
    shift_bit(1'b0);
    shift_bit(1'b1);
    expect_val("sh3_so", 8'h0); check({7'd0, so});
    shift_bit(1'b1);
    expect_val("sh4_sr", 8'hd); check({4'd0, dut.sr});
    expect_val("sh4_so", 8'h1); check({7'd0, so});
    expect_val("pre_upd_select", 8'h0); check({7'd0, select});
    ue = 1'b1;
    step();
    ue = 1'b0;
    expect_val("upd_select", 8'h1); check({7'd0, select});
    expect_val("upd_data", 8'h5); check({5'd0, data_out});
    expect_val("upd_mux", 8'h5); check({5'd0, mux_out});

    // Load ur = 1110 so the mux drives 110
    shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b1);
    ue = 1'b1;
    step();
    ue = 1'b0;
    expect_val("ur1110_mux", 8'h6); check({5'd0, mux_out});

`ifdef FIREBIRD7_TDR_CAPTURE_EN
    ce = 1'b1;
    step();
    ce = 1'b0;
    expect_val("cap_sr", 8'he); check({4'd0, dut.sr});
    expect_val("cap_so0", 8'h0); check({7'd0, so});
    shift_bit(1'b0);
    expect_val("cap_so1", 8'h1); check({7'd0, so});
    shift_bit(1'b0);
    expect_val("cap_so2", 8'h1); check({7'd0, so});
    shift_bit(1'b0);
    expect_val("cap_so3", 8'h1); check({7'd0, so});
    shift_bit(1'b0);
`else
    shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b0); shift_bit(1'b1);
    ce = 1'b1;
    step();
    ce = 1'b0;
    expect_val("nocap_sr", 8'h9); check({4'd0, dut.sr});
    expect_val("nocap_so", 8'h1); check({7'd0, so});
`endif

    // Load sr = 0110, then deselect and toggle every enable
    shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b0);
    sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      se = i[0]; ue = ~i[0]; ce = i[1]; si = 1'b1;
      step();
    end
    se = 1'b0; ue = 1'b0; ce = 1'b0; si = 1'b0;
    expect_val("desel_sr", 8'h6); check({4'd0, dut.sr});
    expect_val("desel_select", 8'h1); check({7'd0, select});
    expect_val("desel_data", 8'h6); check({5'd0, data_out});
    expect_val("desel_so", 8'h0); check({7'd0, so});
    sel = 1'b1;

    // Simultaneous update and shift
    se = 1'b1; ue = 1'b1; si = 1'b1;
    step();
    se = 1'b0; ue = 1'b0; si = 1'b0;
    expect_val("ueSe_select", 8'h0); check({7'd0, select});
    expect_val("ueSe_data", 8'h6); check({5'd0, data_out});
    expect_val("ueSe_sr", 8'hb); check({4'd0, dut.sr});
    expect_val("ueSe_mux", 8'h2); check({5'd0, mux_out});

    // Reset in the middle of a shift load
    shift_bit(1'b1); shift_bit(1'b1);
    rst = 1'b1; se = 1'b1; si = 1'b1;
    step();
    rst = 1'b0; se = 1'b0; si = 1'b0;
    expect_val("midrst_sr", 8'h0); check({4'd0, dut.sr});
    expect_val("midrst_so", 8'h0); check({7'd0, so});
    expect_val("midrst_data", 8'h0); check({5'd0, data_out});

    checks++;
    assert (q_exp.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d pending required 0", q_exp.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
